// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone bus arbiter. Holds the grant for the owner's whole cycle and
// raises a one-cycle bus-error pulse when the owner's strobe goes unanswered too long.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1,
  parameter int TO_W        = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] request,
  input  logic                   stb_g,
  input  logic                   ack_s,
  input  logic                   err_s,
  input  logic                   rty_s,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid,
  output logic                   to_err,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    TOERR = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [TO_W-1:0]        wd_q, wd_d;

  logic [IDX_W-1:0]       win;
  logic [IDX_W-1:0]       cand;
  logic                   found;
  logic                   any_req;
  logic                   owner_req;
  logic                   unanswered;

  // Round-robin pick: first requester after the last winner, wrapping at NUM_MASTERS.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = last_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (cand == IDX_W'(NUM_MASTERS - 1)) ? '0 : cand + 1'b1;
      if (!found && request[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign any_req    = |request;
  assign owner_req  = request[idx_q];
  assign unanswered = stb_g && !(ack_s || err_s || rty_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Ownership: a master keeps the bus while its cyc (request bit) stays high; dropping
  // it releases the bus and the next requester is granted on that same edge.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wd_d    = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = OWNED;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          idx_d        = win;
          last_d       = win;
        end
      end
      OWNED, TOERR: begin
        if (!owner_req) begin
          if (any_req) begin
            state_d      = OWNED;
            grant_d      = '0;
            grant_d[win] = 1'b1;
            idx_d        = win;
            last_d       = win;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (state_q == TOERR) begin
          state_d = OWNED;
        end else if (unanswered) begin
          if (wd_q == TO_W'(TIMEOUT - 1)) begin
            state_d = TOERR;
          end else if (wd_q != '1) begin
            wd_d = wd_q + 1'b1;
          end else begin
            wd_d = wd_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    grant       = grant_q;
    grant_idx   = idx_q;
    grant_valid = |grant_q;
    to_err      = (state_q == TOERR);
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against an ownership/timeout model.
module tb_wb_rr_arbiter;

  localparam int N       = 2;
  localparam int IDX_W   = 1;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     request = '0;
  logic             stb_g = 1'b0;
  logic             ack_s = 1'b0;
  logic             err_s = 1'b0;
  logic             rty_s = 1'b0;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             to_err;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .IDX_W(IDX_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .request(request), .stb_g(stb_g), .ack_s(ack_s),
    .err_s(err_s), .rty_s(rty_s), .grant(grant), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .to_err(to_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;  // -1 when bus is free
  int m_last  = N - 1;
  int m_idx   = 0;
  int m_cnt   = 0;   // consecutive unanswered strobe edges
  bit m_toerr = 0;

  function automatic bit has_req(input logic [N-1:0] req, input int m);
    logic [N-1:0] sh;
    sh = req >> m;
    return sh[0];
  endfunction

  function automatic int next_rr(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (has_req(req, (last + k) % N)) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_idx = 0; m_cnt = 0; m_toerr = 0;
    end else if (m_owner < 0 || !has_req(request, m_owner)) begin
      m_toerr = 0;
      m_cnt   = 0;
      m_owner = next_rr(request, m_last);
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_idx  = m_owner;
      end
    end else if (m_toerr) begin
      m_toerr = 0;
      m_cnt   = 0;
    end else if (stb_g && !(ack_s || err_s || rty_s)) begin
      m_cnt++;
      if (m_cnt == TIMEOUT) begin
        m_toerr = 1;
        m_cnt   = 0;
      end
    end else begin
      m_cnt = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [N-1:0] exp_g;
    exp_g = '0;
    if (rst) begin
      check("rst_grant", 32'(grant), 0);
      check("rst_valid", 32'(grant_valid), 0);
      check("rst_idx", 32'(grant_idx), 0);
      check("rst_to_err", 32'(to_err), 0);
    end else begin
      if (m_owner >= 0) exp_g = N'(1) << m_owner;
      check("grant", 32'(grant), 32'(exp_g));
      check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
      check("grant_idx", 32'(grant_idx), 32'(m_idx));
      check("to_err", 32'(to_err), 32'(m_toerr));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset with both masters requesting
    request = 2'b11;
    ticks(3);
    check("t1_grant", 32'(grant), 0);
    check("t1_valid", 32'(grant_valid), 0);
    check("t1_to_err", 32'(to_err), 0);
    rst = 1'b0;
    tick();
    check("t1_first_grant", 32'(grant), 32'b01);

    // contention: m0 holds 3 clocks, then back-to-back handover both ways
    ticks(2);
    request = 2'b10;
    tick();
    check("t2_handover_grant", 32'(grant), 32'b10);
    check("t2_handover_idx", 32'(grant_idx), 1);
    request = 2'b11;
    ticks(2);
    check("t2_hold_m1", 32'(grant), 32'b10);
    request = 2'b01;
    tick();
    check("t2_back_grant", 32'(grant), 32'b01);
    request = 2'b00;
    tick();
    check("t2_idle_grant", 32'(grant), 0);
    check("t2_idle_idx", 32'(grant_idx), 0);

    // hold: m1 arrives mid-cycle and must wait
    request = 2'b01;
    tick();
    request = 2'b11;
    ticks(3);
    check("t3_hold", 32'(grant), 32'b01);
    request = 2'b10;
    tick();
    check("t3_release", 32'(grant), 32'b10);
    request = 2'b00;
    tick();
    check("t3_idle_idx", 32'(grant_idx), 1);

    // watchdog fires after TIMEOUT unanswered strobes
    request = 2'b01;
    tick();
    stb_g = 1'b1;
    ticks(3);
    check("t4_no_err_yet", 32'(to_err), 0);
    tick();
    check("t4_to_err", 32'(to_err), 1);
    check("t4_grant_kept", 32'(grant), 32'b01);
    tick();
    check("t4_pulse_one", 32'(to_err), 0);
    stb_g = 1'b0;
    tick();

    // ack on the threshold edge suppresses the error and restarts the count
    stb_g = 1'b1;
    ticks(3);
    ack_s = 1'b1;
    tick();
    check("t5_ack_race", 32'(to_err), 0);
    ack_s = 1'b0;
    ticks(3);
    check("t5_restart", 32'(to_err), 0);
    tick();
    check("t5_refire", 32'(to_err), 1);
    tick();

    // release on the threshold edge wins over the watchdog
    ticks(3);
    request = 2'b00;
    tick();
    check("t5b_release_grant", 32'(grant), 0);
    check("t5b_release_to_err", 32'(to_err), 0);
    stb_g = 1'b0;

    // idle, then single requester re-granted
    tick();
    check("t6_idle", 32'(grant_valid), 0);
    request = 2'b10;
    tick();
    check("t6_first", 32'(grant), 32'b10);
    request = 2'b00;
    tick();
    request = 2'b10;
    tick();
    check("t6_regrant", 32'(grant), 32'b10);
    check("t6_regrant_idx", 32'(grant_idx), 1);

    // async reset mid-cycle drops grant immediately
    #2 rst = 1'b1;
    #1;
    check("t7_async_drop", 32'(grant), 0);
    tick();
    rst = 1'b0;

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) request = N'($urandom_range(0, (1 << N) - 1));
      stb_g = ($urandom_range(0, 9) < 7);
      ack_s = ($urandom_range(0, 9) == 0);
      err_s = ($urandom_range(0, 29) == 0);
      rty_s = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
